// File: rtl/issue_queue_nway.sv
// issue_queue_nway: age-ordered, compacting ALU issue queue; index 0 holds the oldest op.
// Latency: issue lanes are registered, one cycle after the select state; wakeup is visible at the next select.
// Backpressure: disp_full = count + DISP_W > DEPTH; dispatch is dropped while full. Optional macro ISQ_PERF_CNT_EN adds perf counters.
`timescale 1ns/1ps
module issue_queue_nway #(
    parameter int DEPTH   = 16,
    parameter int DISP_W  = 2,
    parameter int ISSUE_W = 2,
    parameter int WB_W    = 2,
    parameter int PREG_AW = 6,
    parameter int ROB_AW  = 5,
    parameter int CMD_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [DISP_W-1:0]            disp_en,
    input  logic [DISP_W*CMD_W-1:0]      disp_cmd,
    input  logic [DISP_W*PREG_AW-1:0]    disp_op1,
    input  logic [DISP_W-1:0]            disp_op1_rdy,
    input  logic [DISP_W*32-1:0]         disp_op2,
    input  logic [DISP_W-1:0]            disp_op2_imm,
    input  logic [DISP_W-1:0]            disp_op2_rdy,
    input  logic [DISP_W*PREG_AW-1:0]    disp_prd,
    input  logic [DISP_W*ROB_AW-1:0]     disp_rob,
    output logic                         disp_full,
    input  logic [WB_W-1:0]              wb_valid,
    input  logic [WB_W*PREG_AW-1:0]      wb_prd,
    output logic [ISSUE_W-1:0]           iss_valid,
    output logic [ISSUE_W*CMD_W-1:0]     iss_cmd,
    output logic [ISSUE_W*PREG_AW-1:0]   iss_op1,
    output logic [ISSUE_W*32-1:0]        iss_op2,
    output logic [ISSUE_W-1:0]           iss_op2_imm,
    output logic [ISSUE_W*PREG_AW-1:0]   iss_prd,
    output logic [ISSUE_W*ROB_AW-1:0]    iss_rob,
    output logic [$clog2(DEPTH):0]       occupancy
`ifdef ISQ_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_issued,
    output logic [31:0]                  perf_full_cycles
`endif
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic               vld;
        logic [CMD_W-1:0]   cmd;
        logic [PREG_AW-1:0] op1;
        logic               op1_rdy;
        logic [31:0]        op2;
        logic               op2_imm;
        logic               op2_rdy;
        logic [PREG_AW-1:0] prd;
        logic [ROB_AW-1:0]  rob;
    } entry_t;

    typedef struct packed {
        logic [CMD_W-1:0]   cmd;
        logic [PREG_AW-1:0] op1;
        logic [31:0]        op2;
        logic               op2_imm;
        logic [PREG_AW-1:0] prd;
        logic [ROB_AW-1:0]  rob;
    } iss_t;

    entry_t              ent_q [DEPTH];
    entry_t              ent_d [DEPTH];
    logic [CW-1:0]       count_q, count_d;
    logic [ISSUE_W-1:0]  iss_valid_q;
    iss_t                iss_q [ISSUE_W];

    logic [DEPTH-1:0]    rdy, sel;
    logic [IW-1:0]       below [DEPTH];
    logic [CW-1:0]       n_sel, cai, n_disp;
    logic [ISSUE_W-1:0]  lane_vld;
    logic [IW-1:0]       lane_idx [ISSUE_W];
    entry_t              e_tmp;
    logic [IW-1:0]       dst;

    // True when any valid writeback port carries this tag.
    function automatic logic wb_hit(input logic [PREG_AW-1:0]      tag,
                                    input logic [WB_W-1:0]         v,
                                    input logic [WB_W*PREG_AW-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WB_W; w++) begin
            if (v[w] && (tags[w*PREG_AW +: PREG_AW] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Conservative full: same-cycle issues do not free space for dispatch.
    assign disp_full = ({1'b0, count_q} + (CW+1)'(DISP_W)) > (CW+1)'(DEPTH);
    assign occupancy = count_q;

    // Per-entry readiness from the current (pre-wakeup) state.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = ent_q[i].vld && ent_q[i].op1_rdy && (ent_q[i].op2_imm || ent_q[i].op2_rdy);
        end
    end

    // Oldest-first select: lane j takes the j-th ready entry; below[i] counts selections under entry i.
    always_comb begin
        sel      = '0;
        lane_vld = '0;
        n_sel    = '0;
        for (int j = 0; j < ISSUE_W; j++) lane_idx[j] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            below[i] = n_sel[IW-1:0];
            for (int j = 0; j < ISSUE_W; j++) begin
                if (rdy[i] && (n_sel == CW'(j))) begin
                    lane_vld[j] = 1'b1;
                    lane_idx[j] = IW'(i);
                    sel[i]      = 1'b1;
                end
            end
            if (sel[i]) n_sel = n_sel + CW'(1);
        end
    end

    // Next queue image: wake and compact survivors, then append accepted dispatches behind them.
    always_comb begin
        cai     = count_q - n_sel;
        n_disp  = '0;
        e_tmp   = '0;
        dst     = '0;
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
        if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].vld && !sel[i]) begin
                    e_tmp = ent_q[i];
                    if (!e_tmp.op1_rdy && wb_hit(e_tmp.op1, wb_valid, wb_prd))
                        e_tmp.op1_rdy = 1'b1;
                    if (!e_tmp.op2_imm && !e_tmp.op2_rdy && wb_hit(e_tmp.op2[PREG_AW-1:0], wb_valid, wb_prd))
                        e_tmp.op2_rdy = 1'b1;
                    dst = IW'(i) - below[i];
                    ent_d[dst] = e_tmp;
                end
            end
            if (!disp_full) begin
                for (int k = 0; k < DISP_W; k++) begin
                    if (disp_en[k]) begin
                        e_tmp         = '0;
                        e_tmp.vld     = 1'b1;
                        e_tmp.cmd     = disp_cmd[k*CMD_W +: CMD_W];
                        e_tmp.op1     = disp_op1[k*PREG_AW +: PREG_AW];
                        e_tmp.op1_rdy = disp_op1_rdy[k] ||
                                        wb_hit(disp_op1[k*PREG_AW +: PREG_AW], wb_valid, wb_prd);
                        e_tmp.op2     = disp_op2[k*32 +: 32];
                        e_tmp.op2_imm = disp_op2_imm[k];
                        e_tmp.op2_rdy = disp_op2_imm[k] || disp_op2_rdy[k] ||
                                        wb_hit(disp_op2[k*32 +: PREG_AW], wb_valid, wb_prd);
                        e_tmp.prd     = disp_prd[k*PREG_AW +: PREG_AW];
                        e_tmp.rob     = disp_rob[k*ROB_AW +: ROB_AW];
                        dst           = cai[IW-1:0] + IW'(k);
                        ent_d[dst]    = e_tmp;
                        n_disp        = n_disp + CW'(1);
                    end
                end
            end
            count_d = cai + n_disp;
        end
    end

    // Queue storage and entry count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

    // Issue lane registers; unused lanes keep their old payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid_q <= '0;
            for (int j = 0; j < ISSUE_W; j++) iss_q[j] <= '0;
        end else if (flush) begin
            iss_valid_q <= '0;
        end else begin
            iss_valid_q <= lane_vld;
            for (int j = 0; j < ISSUE_W; j++) begin
                if (lane_vld[j]) begin
                    iss_q[j].cmd     <= ent_q[lane_idx[j]].cmd;
                    iss_q[j].op1     <= ent_q[lane_idx[j]].op1;
                    iss_q[j].op2     <= ent_q[lane_idx[j]].op2;
                    iss_q[j].op2_imm <= ent_q[lane_idx[j]].op2_imm;
                    iss_q[j].prd     <= ent_q[lane_idx[j]].prd;
                    iss_q[j].rob     <= ent_q[lane_idx[j]].rob;
                end
            end
        end
    end

    // Flatten lane registers onto the packed output buses.
    always_comb begin
        iss_valid = iss_valid_q;
        for (int j = 0; j < ISSUE_W; j++) begin
            iss_cmd[j*CMD_W +: CMD_W]     = iss_q[j].cmd;
            iss_op1[j*PREG_AW +: PREG_AW] = iss_q[j].op1;
            iss_op2[j*32 +: 32]           = iss_q[j].op2;
            iss_op2_imm[j]                = iss_q[j].op2_imm;
            iss_prd[j*PREG_AW +: PREG_AW] = iss_q[j].prd;
            iss_rob[j*ROB_AW +: ROB_AW]   = iss_q[j].rob;
        end
    end

`ifdef ISQ_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_full_q, iss_pop;

    // Number of lanes issued in the current cycle.
    always_comb begin
        iss_pop = '0;
        for (int j = 0; j < ISSUE_W; j++) iss_pop = iss_pop + 32'(iss_valid_q[j]);
    end

    // Free-running wrap-around counters; flush does not clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_full_q   <= '0;
        end else begin
            perf_issued_q <= perf_issued_q + iss_pop;
            if (disp_full && (|disp_en)) perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign perf_issued      = perf_issued_q;
    assign perf_full_cycles = perf_full_q;
`endif

endmodule

// File: tb/tb_issue_queue_nway.sv
// Directed bench for issue_queue_nway: table of per-cycle vectors plus hand sequences.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: fill/refuse, full-with-issue, flush and async reset sequences.
`timescale 1ns/1ps
module tb_issue_queue_nway;
    logic        clk, rst, flush;
    logic [1:0]  disp_en;
    logic [9:0]  disp_cmd;
    logic [11:0] disp_op1;
    logic [1:0]  disp_op1_rdy;
    logic [63:0] disp_op2;
    logic [1:0]  disp_op2_imm, disp_op2_rdy;
    logic [11:0] disp_prd;
    logic [9:0]  disp_rob;
    logic        disp_full;
    logic [1:0]  wb_valid;
    logic [11:0] wb_prd;
    logic [1:0]  iss_valid;
    logic [9:0]  iss_cmd;
    logic [11:0] iss_op1;
    logic [63:0] iss_op2;
    logic [1:0]  iss_op2_imm;
    logic [11:0] iss_prd;
    logic [9:0]  iss_rob;
    logic [4:0]  occupancy;
`ifdef ISQ_PERF_CNT_EN
    logic [31:0] perf_issued, perf_full_cycles;
`endif

    int n_chk = 0;
    int n_fail = 0;

    issue_queue_nway dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_en(disp_en), .disp_cmd(disp_cmd), .disp_op1(disp_op1), .disp_op1_rdy(disp_op1_rdy),
        .disp_op2(disp_op2), .disp_op2_imm(disp_op2_imm), .disp_op2_rdy(disp_op2_rdy),
        .disp_prd(disp_prd), .disp_rob(disp_rob), .disp_full(disp_full),
        .wb_valid(wb_valid), .wb_prd(wb_prd),
        .iss_valid(iss_valid), .iss_cmd(iss_cmd), .iss_op1(iss_op1), .iss_op2(iss_op2),
        .iss_op2_imm(iss_op2_imm), .iss_prd(iss_prd), .iss_rob(iss_rob), .occupancy(occupancy)
`ifdef ISQ_PERF_CNT_EN
        , .perf_issued(perf_issued), .perf_full_cycles(perf_full_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int fl, en;
        int a1, ar1, aim, a2, ar2, arob;
        int b1, br1, bim, b2, br2, brob;
        int wv, w0, w1;
        int eiv, er0, er1, eocc, efull;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        flush = 0; disp_en = '0; disp_cmd = '0; disp_op1 = '0; disp_op1_rdy = '0;
        disp_op2 = '0; disp_op2_imm = '0; disp_op2_rdy = '0; disp_prd = '0; disp_rob = '0;
        wb_valid = '0; wb_prd = '0;
    endtask

    task automatic set_slot(input int k, input int op1, input int r1, input int imm,
                            input int op2, input int r2, input int rob);
        disp_op1[k*6 +: 6]    = 6'(op1);
        disp_op1_rdy[k]       = r1[0];
        disp_op2_imm[k]       = imm[0];
        disp_op2[k*32 +: 32]  = 32'(op2);
        disp_op2_rdy[k]       = r2[0];
        disp_rob[k*5 +: 5]    = 5'(rob);
        disp_cmd[k*5 +: 5]    = 5'(rob + 3);
        disp_prd[k*6 +: 6]    = 6'(rob);
    endtask

    task automatic set_wb(input int v, input int t0, input int t1);
        wb_valid = 2'(v);
        wb_prd   = {6'(t1), 6'(t0)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int iv, input int r0, input int r1,
                           input int occ, input int full);
        chk({tag, " iss_valid"}, int'(iss_valid), iv);
        chk({tag, " occupancy"}, int'(occupancy), occ);
        chk({tag, " disp_full"}, int'(disp_full), full);
        if (iv[0]) begin
            chk({tag, " lane0 rob"}, int'(iss_rob[4:0]), r0);
            chk({tag, " lane0 cmd"}, int'(iss_cmd[4:0]), r0 + 3);
        end
        if (iv[1]) begin
            chk({tag, " lane1 rob"}, int'(iss_rob[9:5]), r1);
            chk({tag, " lane1 prd"}, int'(iss_prd[11:6]), r1);
        end
    endtask

    initial begin
        //            fl en  a: op1 r1 im op2 r2 rob   b: op1 r1 im op2 r2 rob  wv w0 w1  eiv r0 r1 occ full
        vt[0]  = '{0, 3,  1, 1, 1, 0, 0, 0,   2, 1, 1, 0, 0, 1,   0, 0, 0,   0, 0, 0, 2, 0};
        vt[1]  = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,   3, 0, 1, 0, 0};
        vt[2]  = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0};
        vt[3]  = '{0, 1,  9, 0, 1, 0, 0, 2,   0, 0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 1, 0};
        vt[4]  = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 1, 0};
        vt[5]  = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   1, 9, 0,   0, 0, 0, 1, 0};
        vt[6]  = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,   1, 2, 0, 0, 0};
        vt[7]  = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0};
        vt[8]  = '{0, 1,  5, 0, 1, 0, 0, 3,   0, 0, 0, 0, 0, 0,   2, 0, 5,   0, 0, 0, 1, 0};
        vt[9]  = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,   1, 3, 0, 0, 0};
        vt[10] = '{0, 3,  1, 1, 1, 0, 0, 4,   2, 1, 1, 0, 0, 5,   0, 0, 0,   0, 0, 0, 2, 0};
        vt[11] = '{0, 1,  3, 1, 1, 0, 0, 6,   0, 0, 0, 0, 0, 0,   0, 0, 0,   3, 4, 5, 1, 0};
        vt[12] = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,   1, 6, 0, 0, 0};
        vt[13] = '{0, 3,  1, 1, 0,12, 0, 7,  13, 0, 1, 0, 0, 8,   0, 0, 0,   0, 0, 0, 2, 0};
        vt[14] = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   3,12,12,   0, 0, 0, 2, 0};
        vt[15] = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   3,12,13,   1, 7, 0, 1, 0};
        vt[16] = '{0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,   1, 8, 0, 0, 0};

        clr();
        rst = 1'b1;
        #1;
        chk("reset iss_valid", int'(iss_valid), 0);
        chk("reset occupancy", int'(occupancy), 0);
        chk("reset disp_full", int'(disp_full), 0);
        chk("reset iss_rob", int'(iss_rob), 0);
        #1;
        rst = 1'b0;

        // Per-cycle vectors: basic issue, wakeup timing, bypass, ordering, op2 wakeup.
        for (int r = 0; r < 17; r++) begin
            clr();
            flush   = vt[r].fl[0];
            disp_en = 2'(vt[r].en);
            set_slot(0, vt[r].a1, vt[r].ar1, vt[r].aim, vt[r].a2, vt[r].ar2, vt[r].arob);
            set_slot(1, vt[r].b1, vt[r].br1, vt[r].bim, vt[r].b2, vt[r].br2, vt[r].brob);
            set_wb(vt[r].wv, vt[r].w0, vt[r].w1);
            step();
            chk_out($sformatf("vec%0d", r), vt[r].eiv, vt[r].er0, vt[r].er1, vt[r].eocc, vt[r].efull);
        end

        // Fill with 16 blocked ops (op1 tag 20+rob).
        for (int k = 0; k < 8; k++) begin
            clr();
            disp_en = 2'b11;
            set_slot(0, 20 + 2*k, 0, 1, 0, 0, 2*k);
            set_slot(1, 21 + 2*k, 0, 1, 0, 0, 2*k + 1);
            step();
            chk_out($sformatf("fill%0d", k), 0, 0, 0, 2*k + 2, (2*k + 4 > 16) ? 1 : 0);
        end

        // Dispatch while full is refused.
        clr();
        disp_en = 2'b01;
        set_slot(0, 1, 1, 1, 0, 0, 30);
        #1;
        chk("full comb disp_full", int'(disp_full), 1);
        step();
        chk_out("full refuse", 0, 0, 0, 16, 1);

        // Wake entries 3 and 7.
        clr();
        set_wb(3, 23, 27);
        step();
        chk_out("wake 3,7", 0, 0, 0, 16, 1);

        // Full queue issuing two: dispatch still refused.
        clr();
        disp_en = 2'b11;
        set_slot(0, 1, 1, 1, 0, 0, 30);
        set_slot(1, 2, 1, 1, 0, 0, 31);
        step();
        chk_out("issue 3,7", 3, 3, 7, 14, 0);

        // Probe compaction/age order: wake oldest and youngest together.
        clr();
        set_wb(3, 35, 20);
        step();
        chk_out("wake 0,15", 0, 0, 0, 14, 0);
        clr();
        set_wb(3, 30, 24);
        step();
        chk_out("issue 0,15", 3, 0, 15, 12, 0);
        clr();
        set_wb(1, 25, 0);
        step();
        chk_out("issue 4,10", 3, 4, 10, 10, 0);

        // Flush with 10 entries (rob5 ready) while dispatching 2 and waking 1.
        clr();
        flush   = 1'b1;
        disp_en = 2'b11;
        set_slot(0, 1, 1, 1, 0, 0, 20);
        set_slot(1, 2, 1, 1, 0, 0, 21);
        set_wb(1, 21, 0);
        step();
        chk_out("flush", 0, 0, 0, 0, 0);
        clr();
        step();
        chk_out("post flush", 0, 0, 0, 0, 0);
        clr();
        disp_en = 2'b11;
        set_slot(0, 1, 1, 1, 0, 0, 9);
        set_slot(1, 2, 1, 1, 0, 0, 10);
        step();
        chk_out("redisp", 0, 0, 0, 2, 0);
        clr();
        step();
        chk_out("redisp issue", 3, 9, 10, 0, 0);

        // Async reset between edges.
        clr();
        disp_en = 2'b11;
        set_slot(0, 40, 0, 1, 0, 0, 12);
        set_slot(1, 41, 0, 1, 0, 0, 13);
        step();
        chk_out("pre reset", 0, 0, 0, 2, 0);
        clr();
        #3;
        rst = 1'b1;
        #1;
        chk("async occupancy", int'(occupancy), 0);
        chk("async iss_valid", int'(iss_valid), 0);
        chk("async iss_rob", int'(iss_rob), 0);
        chk("async iss_cmd", int'(iss_cmd), 0);
        chk("async disp_full", int'(disp_full), 0);
        #2;
        rst = 1'b0;
        step();
        chk_out("post reset", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
